cs_address_sequencer: RTL and testbench

- Microsequencer stage directly downstream of the branch-condition logic. It consumes the registered 2-bit branch type (Tipo) and produces the next control-store address (CSAI) for the microcode ROM.
- Selects between three next-address sources: incremented current address (Next), MIR jump address (Jump), and the opcode-derived dispatch address (Decode).
- Holds its address register while the datapath memory is busy. Flags illegal Tipo codes and address overflow.

---
 rtl/cs_address_sequencer_pkg.sv | 24 ++
 rtl/cs_address_mux.sv | 44 ++++
 rtl/cs_address_sequencer.sv | 92 +++++++++
 tb/tb_cs_address_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/cs_address_sequencer_pkg.sv
// Shared constants for the control-store address sequencer and the
// branch-condition stage that feeds it.
package cs_address_sequencer_pkg;

  // Default bus widths
  localparam int ADDR_W    = 11;
  localparam int TIPO_W    = 2;
  localparam int OPFIELD_W = 8;

  // Branch-type encodings, shared with the branch-condition stage
  localparam logic [TIPO_W-1:0] TIPO_NEXT    = 2'b00;
  localparam logic [TIPO_W-1:0] TIPO_JUMP    = 2'b01;
  localparam logic [TIPO_W-1:0] TIPO_DECODE  = 2'b10;
  localparam logic [TIPO_W-1:0] TIPO_ILLEGAL = 2'b11;

  // Control FSM states
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  // Decode dispatch address = {prefix, opfield, pad}
  localparam logic [0:0] DECODE_PREFIX = 1'b1;
  localparam logic [1:0] DECODE_PAD    = 2'b00;

endpackage

// File: rtl/cs_address_mux.sv
// Combinational next-address selection: incrementer, jump target and
// opcode dispatch, plus overflow and illegal-code detection.
module cs_address_mux
  import cs_address_sequencer_pkg::*;
#(
  parameter int ADDR    = 11,
  parameter int OPFIELD = 8
) (
  input  logic [ADDR-1:0]    csai,
  input  logic [1:0]         tipo,
  input  logic [ADDR-1:0]    jump_addr,
  input  logic [OPFIELD-1:0] op_field,
  output logic [ADDR-1:0]    next_addr,
  output logic               overflow,
  output logic               illegal
);

  logic [ADDR-1:0] incr;
  logic            carry;

  // Incrementer; the carry out marks a wrap from all-ones to zero
  assign {carry, incr} = {1'b0, csai} + {{ADDR{1'b0}}, 1'b1};

  // Three-way source select; the illegal code falls back to Next
  always_comb begin
    next_addr = incr;
    overflow  = 1'b0;
    illegal   = 1'b0;
    case (tipo)
      TIPO_JUMP:   next_addr = jump_addr;
      TIPO_DECODE: next_addr = {DECODE_PREFIX, op_field, DECODE_PAD};
      TIPO_ILLEGAL: begin
        next_addr = incr;
        overflow  = carry;
        illegal   = 1'b1;
      end
      default: begin
        next_addr = incr;
        overflow  = carry;
      end
    endcase
  end

endmodule

// File: rtl/cs_address_sequencer.sv
// Control-store address sequencer: holds the microcode address register,
// a RUN/HOLD stall FSM, the decode strobe and a sticky error flag.
module cs_address_sequencer
  import cs_address_sequencer_pkg::*;
#(
  parameter int CS_ADDRESS_SEQUENCER_ADDR    = 11,
  parameter int CS_ADDRESS_SEQUENCER_TIPO    = 2,
  parameter int CS_ADDRESS_SEQUENCER_OPFIELD = 8
) (
  input  logic                                    CS_ADDRESS_SEQUENCER_CLOCK_50,
  input  logic                                    CS_ADDRESS_SEQUENCER_ResetInLow_In,
  input  logic [CS_ADDRESS_SEQUENCER_TIPO-1:0]    CS_ADDRESS_SEQUENCER_Tipo_InBus,
  input  logic [CS_ADDRESS_SEQUENCER_ADDR-1:0]    CS_ADDRESS_SEQUENCER_JumpAddr_InBus,
  input  logic [CS_ADDRESS_SEQUENCER_OPFIELD-1:0] CS_ADDRESS_SEQUENCER_OpField_InBus,
  input  logic                                    CS_ADDRESS_SEQUENCER_Stall_In,
  output logic [CS_ADDRESS_SEQUENCER_ADDR-1:0]    CS_ADDRESS_SEQUENCER_Csai_OutBus,
  output logic                                    CS_ADDRESS_SEQUENCER_DecodeStrobe_Out,
  output logic                                    CS_ADDRESS_SEQUENCER_Error_Out
);

  localparam int AW = CS_ADDRESS_SEQUENCER_ADDR;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic [1:0]    tipo;

  logic [0:0]    state_reg;
  logic [0:0]    state_next;
  logic [AW-1:0] csai_reg;
  logic          strobe_reg;
  logic          error_reg;

  logic [AW-1:0] next_addr;
  logic          overflow;
  logic          illegal;
  logic          accept;

  assign clk   = CS_ADDRESS_SEQUENCER_CLOCK_50;
  assign rst_n = CS_ADDRESS_SEQUENCER_ResetInLow_In;
  assign stall = CS_ADDRESS_SEQUENCER_Stall_In;
  assign tipo  = CS_ADDRESS_SEQUENCER_Tipo_InBus;

  cs_address_mux #(
    .ADDR    (CS_ADDRESS_SEQUENCER_ADDR),
    .OPFIELD (CS_ADDRESS_SEQUENCER_OPFIELD)
  ) u_mux (
    .csai      (csai_reg),
    .tipo      (tipo),
    .jump_addr (CS_ADDRESS_SEQUENCER_JumpAddr_InBus),
    .op_field  (CS_ADDRESS_SEQUENCER_OpField_InBus),
    .next_addr (next_addr),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  // RUN/HOLD transitions; leaving HOLD samples the new Tipo on the same edge
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     state_next = stall ? HOLD : RUN;
      HOLD:    state_next = stall ? HOLD : RUN;
      default: state_next = RUN;
    endcase
  end

  assign accept = (state_next == RUN);

  // Address register, strobe and sticky error; reset clears all immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= RUN;
      csai_reg   <= '0;
      strobe_reg <= 1'b0;
      error_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        csai_reg   <= next_addr;
        strobe_reg <= (tipo == TIPO_DECODE);
        error_reg  <= error_reg | illegal | overflow;
      end else begin
        strobe_reg <= 1'b0;
      end
    end
  end

  assign CS_ADDRESS_SEQUENCER_Csai_OutBus        = csai_reg;
  assign CS_ADDRESS_SEQUENCER_DecodeStrobe_Out   = strobe_reg;
  assign CS_ADDRESS_SEQUENCER_Error_Out          = error_reg;

endmodule

// File: tb/tb_cs_address_sequencer.sv
// Directed, table-driven bench for the control-store address sequencer.
module tb_cs_address_sequencer;

  logic        clk;
  logic        rst_n;
  logic [1:0]  tipo;
  logic [10:0] jump;
  logic [7:0]  op;
  logic        stall;
  logic [10:0] csai;
  logic        strobe;
  logic        err;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic        rst;      // pulse async reset (no clock) before this vector
    logic        stall;
    logic [1:0]  tipo;
    logic [10:0] jump;
    logic [7:0]  op;
    logic [10:0] e_csai;
    logic        e_strobe;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  cs_address_sequencer dut (
    .CS_ADDRESS_SEQUENCER_CLOCK_50         (clk),
    .CS_ADDRESS_SEQUENCER_ResetInLow_In    (rst_n),
    .CS_ADDRESS_SEQUENCER_Tipo_InBus       (tipo),
    .CS_ADDRESS_SEQUENCER_JumpAddr_InBus   (jump),
    .CS_ADDRESS_SEQUENCER_OpField_InBus    (op),
    .CS_ADDRESS_SEQUENCER_Stall_In         (stall),
    .CS_ADDRESS_SEQUENCER_Csai_OutBus      (csai),
    .CS_ADDRESS_SEQUENCER_DecodeStrobe_Out (strobe),
    .CS_ADDRESS_SEQUENCER_Error_Out        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic [1:0] t, input logic [10:0] j,
                     input logic [7:0] o, input logic [10:0] ec, input logic es, input logic ee);
    vec_t v;
    v.rst = r; v.stall = s; v.tipo = t; v.jump = j; v.op = o;
    v.e_csai = ec; v.e_strobe = es; v.e_err = ee;
    tbl.push_back(v);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    tipo  = 2'b00;
    jump  = '0;
    op    = '0;

    //   rst stall tipo  jump     op      csai     strb err
    add(0, 0, 2'b00, 11'h000, 8'h00, 11'h001, 0, 0);
    add(0, 0, 2'b00, 11'h000, 8'h00, 11'h002, 0, 0);
    add(0, 0, 2'b00, 11'h000, 8'h00, 11'h003, 0, 0);
    add(0, 0, 2'b01, 11'h005, 8'h00, 11'h005, 0, 0);
    add(0, 0, 2'b01, 11'h40C, 8'h00, 11'h40C, 0, 0);
    add(0, 0, 2'b10, 11'h000, 8'h80, 11'h600, 1, 0);
    add(0, 0, 2'b00, 11'h000, 8'h80, 11'h601, 0, 0);
    add(0, 0, 2'b10, 11'h000, 8'h80, 11'h600, 1, 0);
    add(0, 0, 2'b10, 11'h000, 8'h3F, 11'h4FC, 1, 0);
    add(0, 0, 2'b01, 11'h7FF, 8'h00, 11'h7FF, 0, 0);
    add(0, 0, 2'b01, 11'h7FF, 8'h00, 11'h7FF, 0, 0);
    add(0, 0, 2'b10, 11'h000, 8'h00, 11'h400, 1, 0);
    add(0, 0, 2'b01, 11'h7FF, 8'h00, 11'h7FF, 0, 0);
    add(0, 0, 2'b00, 11'h000, 8'h00, 11'h000, 0, 1);
    add(0, 0, 2'b01, 11'h010, 8'h00, 11'h010, 0, 1);
    add(1, 0, 2'b01, 11'h007, 8'h00, 11'h007, 0, 0);
    add(0, 1, 2'b01, 11'h123, 8'h00, 11'h007, 0, 0);
    add(0, 1, 2'b01, 11'h123, 8'h00, 11'h007, 0, 0);
    add(0, 1, 2'b01, 11'h123, 8'h00, 11'h007, 0, 0);
    add(0, 1, 2'b01, 11'h123, 8'h00, 11'h007, 0, 0);
    add(0, 0, 2'b01, 11'h123, 8'h00, 11'h123, 0, 0);
    add(0, 0, 2'b10, 11'h000, 8'h80, 11'h600, 1, 0);
    add(0, 1, 2'b11, 11'h000, 8'h80, 11'h600, 0, 0);
    add(0, 1, 2'b10, 11'h000, 8'h80, 11'h600, 0, 0);
    add(0, 0, 2'b01, 11'h020, 8'h00, 11'h020, 0, 0);
    add(0, 0, 2'b11, 11'h000, 8'h00, 11'h021, 0, 1);
    add(0, 0, 2'b01, 11'h7FF, 8'h00, 11'h7FF, 0, 1);
    add(0, 0, 2'b11, 11'h000, 8'h00, 11'h000, 0, 1);

    // Reset state, then release on a falling edge
    repeat (2) @(negedge clk);
    check("reset_csai",   csai,           11'h000);
    check("reset_strobe", {10'd0, strobe}, 11'd0);
    check("reset_err",    {10'd0, err},    11'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      if (tbl[i].rst) begin
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_csai", csai,           11'h000);
        check("async_rst_err",  {10'd0, err},    11'd0);
        rst_n = 1'b1;
      end
      stall = tbl[i].stall;
      tipo  = tbl[i].tipo;
      jump  = tbl[i].jump;
      op    = tbl[i].op;
      @(posedge clk);
      #1;
      $display("vec %0d: stall=%b tipo=%b jump=%h op=%h -> csai=%h strobe=%b err=%b",
               i, tbl[i].stall, tbl[i].tipo, tbl[i].jump, tbl[i].op, csai, strobe, err);
      check($sformatf("v%0d_csai", i),   csai,             tbl[i].e_csai);
      check($sformatf("v%0d_strobe", i), {10'd0, strobe},  {10'd0, tbl[i].e_strobe});
      check($sformatf("v%0d_err", i),    {10'd0, err},     {10'd0, tbl[i].e_err});
    end

    // Mid-stall reset: leave an error set, stall, then reset between edges
    @(negedge clk);
    stall = 1'b0; tipo = 2'b01; jump = 11'h020;
    @(posedge clk); #1;
    @(negedge clk);
    tipo = 2'b11;
    @(posedge clk); #1;
    check("pre_stall_csai", csai,         11'h021);
    check("pre_stall_err",  {10'd0, err},  11'd1);
    @(negedge clk);
    stall = 1'b1; tipo = 2'b01; jump = 11'h555;
    @(posedge clk); #1;
    check("stall_hold_csai", csai, 11'h021);
    #2 rst_n = 1'b0;
    #1;
    $display("mid-stall reset: csai=%h strobe=%b err=%b", csai, strobe, err);
    check("midstall_rst_csai",   csai,            11'h000);
    check("midstall_rst_err",    {10'd0, err},    11'd0);
    check("midstall_rst_strobe", {10'd0, strobe}, 11'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
